inta_sequencer: RTL and testbench

//  Interrupt-acknowledge responder of the 8259A PIC: owns the in-service bits from the CPU side.

---
 rtl/inta_sequencer.sv | 167 ++++++++++++++++
 tb/tb_inta_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// inta_sequencer
// Interrupt-acknowledge responder of an 8259A-style PIC. It owns the in-service
// register (ISR), raises INT toward the CPU, walks the two-pulse 8086 INTA cycle
// and retires in-service levels on specific / non-specific EOI commands.
//
// Optional feature macro: AUTO_EOI_EN
//   defined   -> with autoEoi=1 the ISR bit set by the first INTA pulse is
//                cleared on the same edge the vector is driven.
//   undefined -> autoEoi is ignored; ISR bits clear only through EOI commands.

module inta_sequencer #(
    parameter int SPURIOUS_LEVEL = 7,
    parameter int VEC_HOLD       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irrPending,
    input  logic       intaPulse,
    input  logic [4:0] vectorBase,
    input  logic       eoiValid,
    input  logic       eoiSpecific,
    input  logic [2:0] eoiLevel,
    input  logic       autoEoi,
    output logic       intReq,
    output logic [7:0] ISR_reg,
    output logic [7:0] clearIRR,
    output logic [7:0] dataOut,
    output logic       dataOutEn
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2
    } state_t;

    state_t     state_q;
    logic       intReq_q;
    logic [7:0] isr_q;
    logic [7:0] clearIrr_q;
    logic [7:0] dataOut_q;
    logic       dataOutEn_q;
    logic [2:0] level_q;
    logic       levelValid_q;
    logic [2:0] holdCnt_q;

    logic [3:0] pendEnc;
    logic [3:0] isrEnc;
    logic       qualify_d;
    logic       ackStrobe;
    logic       vecStrobe;
    logic [7:0] eoiMask_d;
    logic [7:0] setMask_d;
    logic [7:0] autoMask_d;
    logic [7:0] isr_d;
    logic       autoEoiActive;

    // Fixed-priority encoder: returns {found, index of lowest set bit}; bit 0
    // is the highest priority level.
    function automatic logic [3:0] prioEnc(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

`ifdef AUTO_EOI_EN
    assign autoEoiActive = autoEoi;
`else
    assign autoEoiActive = autoEoi & 1'b0;
`endif

    // Priority resolution, EOI/ack/auto-EOI masks and the next ISR value.
    // Within one edge the EOI clear is applied before the acknowledge set, so
    // a set on the same level as an EOI wins.
    always_comb begin
        pendEnc    = prioEnc(irrPending);
        isrEnc     = prioEnc(isr_q);
        qualify_d  = pendEnc[3] && (!isrEnc[3] || (pendEnc[2:0] < isrEnc[2:0]));
        ackStrobe  = intaPulse && ((state_q == IDLE) || (state_q == REQ));
        vecStrobe  = intaPulse && (state_q == ACK1);

        eoiMask_d = 8'd0;
        if (eoiValid) begin
            if (eoiSpecific) begin
                eoiMask_d = 8'd1 << eoiLevel;
            end else if (isrEnc[3]) begin
                eoiMask_d = 8'd1 << isrEnc[2:0];
            end
        end

        setMask_d = 8'd0;
        if (ackStrobe && qualify_d) begin
            setMask_d = 8'd1 << pendEnc[2:0];
        end

        autoMask_d = 8'd0;
        if (vecStrobe && levelValid_q && autoEoiActive) begin
            autoMask_d = 8'd1 << level_q;
        end

        isr_d = ((isr_q & ~eoiMask_d) | setMask_d) & ~autoMask_d;
    end

    // INTA sequencer state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            intReq_q     <= 1'b0;
            isr_q        <= 8'd0;
            clearIrr_q   <= 8'd0;
            dataOut_q    <= 8'd0;
            dataOutEn_q  <= 1'b0;
            level_q      <= 3'd0;
            levelValid_q <= 1'b0;
            holdCnt_q    <= 3'd0;
        end else begin
            isr_q      <= isr_d;
            clearIrr_q <= 8'd0;

            case (state_q)
                IDLE, REQ: begin
                    if (intaPulse) begin
                        level_q      <= qualify_d ? pendEnc[2:0] : 3'(SPURIOUS_LEVEL);
                        levelValid_q <= qualify_d;
                        clearIrr_q   <= setMask_d;
                        intReq_q     <= 1'b0;
                        state_q      <= ACK1;
                    end else if ((state_q == IDLE) && qualify_d) begin
                        intReq_q <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                ACK1: begin
                    if (intaPulse) begin
                        dataOut_q <= {vectorBase, level_q};
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    intReq_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase

            if (vecStrobe) begin
                dataOutEn_q <= 1'b1;
                holdCnt_q   <= 3'(VEC_HOLD - 1);
            end else if (holdCnt_q != 3'd0) begin
                holdCnt_q <= holdCnt_q - 3'd1;
            end else begin
                dataOutEn_q <= 1'b0;
            end
        end
    end

    assign intReq    = intReq_q;
    assign ISR_reg   = isr_q;
    assign clearIRR  = clearIrr_q;
    assign dataOut   = dataOut_q;
    assign dataOutEn = dataOutEn_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer
// Directed bench for inta_sequencer: acknowledge cycles, nesting, spurious
// INTA, EOI commands, EOI/ack collision, mid-cycle reset and the AUTO_EOI_EN
// variant (expected ISR follows the macro).

module tb_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] irrPending;
    logic       intaPulse;
    logic [4:0] vectorBase;
    logic       eoiValid;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;
    logic       autoEoi;
    logic       intReq;
    logic [7:0] ISR_reg;
    logic [7:0] clearIRR;
    logic [7:0] dataOut;
    logic       dataOutEn;

    int total = 0;
    int bad   = 0;

    inta_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irrPending (irrPending),
        .intaPulse  (intaPulse),
        .vectorBase (vectorBase),
        .eoiValid   (eoiValid),
        .eoiSpecific(eoiSpecific),
        .eoiLevel   (eoiLevel),
        .autoEoi    (autoEoi),
        .intReq     (intReq),
        .ISR_reg    (ISR_reg),
        .clearIRR   (clearIRR),
        .dataOut    (dataOut),
        .dataOutEn  (dataOutEn)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, wait for the edge, then settle 1 ns past it.
    task automatic applyStimulus(input logic [7:0] irr, input logic pulse);
        irrPending = irr;
        intaPulse  = pulse;
        @(posedge clk);
        #1;
        intaPulse = 1'b0;
        eoiValid  = 1'b0;
    endtask

    // Full two-pulse acknowledge of a request, used to build up ISR state.
    task automatic ackLevel(input logic [7:0] irr);
        applyStimulus(irr, 1'b0);
        applyStimulus(irr, 1'b1);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        rst_n       = 1'b0;
        irrPending  = 8'h00;
        intaPulse   = 1'b0;
        vectorBase  = 5'h11;
        eoiValid    = 1'b0;
        eoiSpecific = 1'b0;
        eoiLevel    = 3'd0;
        autoEoi     = 1'b0;
        #12;
        checkOutput("rst_intReq", {7'd0, intReq}, 8'h00);
        checkOutput("rst_isr", ISR_reg, 8'h00);
        checkOutput("rst_dataOutEn", {7'd0, dataOutEn}, 8'h00);
        rst_n = 1'b1;

        // Basic acknowledge of IR3
        applyStimulus(8'h08, 1'b0);
        checkOutput("t1_intReq", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h08, 1'b1);
        checkOutput("t1_isr", ISR_reg, 8'h08);
        checkOutput("t1_clearIRR", clearIRR, 8'h08);
        checkOutput("t1_intReqDrop", {7'd0, intReq}, 8'h00);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t1_clearIRRpulse", clearIRR, 8'h00);
        checkOutput("t1_enIdle", {7'd0, dataOutEn}, 8'h00);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t1_dataOut", dataOut, 8'h8B);
        checkOutput("t1_en", {7'd0, dataOutEn}, 8'h01);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t1_enDrop", {7'd0, dataOutEn}, 8'h00);
        checkOutput("t1_dataHold", dataOut, 8'h8B);

        // Specific EOI on level 3, then build ISR=04
        eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd3;
        applyStimulus(8'h00, 1'b0);
        checkOutput("eoi3", ISR_reg, 8'h00);
        ackLevel(8'h04);
        checkOutput("ack2_isr", ISR_reg, 8'h04);
        checkOutput("ack2_data", dataOut, 8'h8A);

        // Nesting: lower priority blocked, higher priority allowed
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h10, 1'b0);
        checkOutput("t2_blocked", {7'd0, intReq}, 8'h00);
        applyStimulus(8'h02, 1'b0);
        checkOutput("t2_intReq", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h02, 1'b1);
        checkOutput("t2_isr", ISR_reg, 8'h06);
        checkOutput("t2_clearIRR", clearIRR, 8'h02);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t2_data", dataOut, 8'h89);
        applyStimulus(8'h00, 1'b0);

        // Spurious: request vanishes before INTA
        applyStimulus(8'h01, 1'b0);
        checkOutput("t3_intReq", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t3_intReqHeld", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t3_isr", ISR_reg, 8'h06);
        checkOutput("t3_clearIRR", clearIRR, 8'h00);
        checkOutput("t3_intReqDrop", {7'd0, intReq}, 8'h00);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t3_data", dataOut, 8'h8F);
        checkOutput("t3_en", {7'd0, dataOutEn}, 8'h01);
        applyStimulus(8'h00, 1'b0);

        // Non-specific EOIs drain ISR, then build ISR=26
        eoiValid = 1'b1; eoiSpecific = 1'b0;
        applyStimulus(8'h00, 1'b0);
        checkOutput("nseoi_a", ISR_reg, 8'h04);
        eoiValid = 1'b1; eoiSpecific = 1'b0;
        applyStimulus(8'h00, 1'b0);
        checkOutput("nseoi_b", ISR_reg, 8'h00);
        ackLevel(8'h20);
        ackLevel(8'h04);
        ackLevel(8'h02);
        checkOutput("t4_build", ISR_reg, 8'h26);
        eoiValid = 1'b1; eoiSpecific = 1'b0;
        applyStimulus(8'h00, 1'b0);
        checkOutput("t4_nseoi", ISR_reg, 8'h24);
        eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd5;
        applyStimulus(8'h00, 1'b0);
        checkOutput("t4_seoi5", ISR_reg, 8'h04);
        eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd0;
        applyStimulus(8'h00, 1'b0);
        checkOutput("t4_seoi0", ISR_reg, 8'h04);

        // EOI and acknowledge on the same edge
        applyStimulus(8'h02, 1'b0);
        checkOutput("coll_intReq", {7'd0, intReq}, 8'h01);
        eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd2;
        applyStimulus(8'h02, 1'b1);
        checkOutput("coll_isr", ISR_reg, 8'h02);
        checkOutput("coll_clearIRR", clearIRR, 8'h02);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("coll_data", dataOut, 8'h89);
        applyStimulus(8'h00, 1'b0);

        // Reset between the two INTA pulses
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b1);
        checkOutput("t5_isrPre", ISR_reg, 8'h03);
        rst_n = 1'b0;
        #2;
        checkOutput("t5_intReq", {7'd0, intReq}, 8'h00);
        checkOutput("t5_isr", ISR_reg, 8'h00);
        checkOutput("t5_clearIRR", clearIRR, 8'h00);
        checkOutput("t5_dataOut", dataOut, 8'h00);
        checkOutput("t5_en", {7'd0, dataOutEn}, 8'h00);
        rst_n   = 1'b1;
        autoEoi = 1'b1;
        applyStimulus(8'h01, 1'b0);
        checkOutput("t5_restart", {7'd0, intReq}, 8'h01);
        applyStimulus(8'h01, 1'b1);
        checkOutput("t6_isrSet", ISR_reg, 8'h01);
        checkOutput("t6_clearIRR", clearIRR, 8'h01);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t6_en", {7'd0, dataOutEn}, 8'h01);
        checkOutput("t6_data", dataOut, 8'h88);
`ifdef AUTO_EOI_EN
        checkOutput("t6_isrAuto", ISR_reg, 8'h00);
`else
        checkOutput("t6_isrKeep", ISR_reg, 8'h01);
`endif
        applyStimulus(8'h00, 1'b0);
        checkOutput("t6_enDrop", {7'd0, dataOutEn}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
